// File: rtl/apb_timer_regs_mc.sv
// apb_timer_regs_mc
// APB slave register file for a NUM_CH-channel timer. Each channel has four
// word registers at paddr = {channel, offset}: TDR (reload value), TCR
// (load/updown/en/cks control), TSR (OVF/UDF status, write-1-to-clear) and
// TIER (interrupt enables). Transfers are stretched by WAIT_CYCLES access
// wait states; accesses to a channel >= NUM_CH complete with pslverr.
//
// Ports:
//   pclk, preset_n           clock, asynchronous active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB address / write data
//   prdata, pready, pslverr  APB response (prdata is combinational)
//   ovf_trig, udf_trig       per-channel overflow/underflow pulses from counters
//   tdr, en, updown, load, cks  per-channel control vectors to the counters
//   irq, irq_any             registered per-channel interrupts and their OR
module apb_timer_regs_mc #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic [NUM_CH-1:0]        ovf_trig,
  input  logic [NUM_CH-1:0]        udf_trig,
  output logic [DATA_W*NUM_CH-1:0] tdr,
  output logic [NUM_CH-1:0]        en,
  output logic [NUM_CH-1:0]        updown,
  output logic [NUM_CH-1:0]        load,
  output logic [2*NUM_CH-1:0]      cks,
  output logic [NUM_CH-1:0]        irq,
  output logic                     irq_any
);

  logic [2:0]        wait_cnt;
  logic [31:0]       ch_idx;
  logic [1:0]        offset;
  logic              ch_valid;
  logic              wr_commit;
  logic [NUM_CH-1:0] wr_tdr, wr_tcr, wr_tsr, wr_tier;

  logic [DATA_W-1:0] tdr_q [NUM_CH];
  logic [1:0]        cks_q [NUM_CH];
  logic [NUM_CH-1:0] en_q, updown_q, load_q;
  logic [NUM_CH-1:0] ovf_q, udf_q, ovf_ie_q, udf_ie_q, irq_q;

  assign ch_idx   = 32'(paddr[ADDR_W-1:2]);
  assign offset   = paddr[1:0];
  assign ch_valid = (ch_idx < 32'(NUM_CH));

  // Gated by preset_n so pready is low throughout reset even with WAIT_CYCLES=0.
  assign pready    = preset_n & psel & penable & (wait_cnt == 3'(WAIT_CYCLES));
  assign pslverr   = pready & ~ch_valid;
  assign wr_commit = pready & pwrite & ch_valid;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (!psel || pready) begin
      wait_cnt <= '0;
    end else if (penable) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  always_comb begin
    wr_tdr  = '0;
    wr_tcr  = '0;
    wr_tsr  = '0;
    wr_tier = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_commit && (ch_idx == c)) begin
        case (offset)
          2'd0: wr_tdr[c]  = 1'b1;
          2'd1: wr_tcr[c]  = 1'b1;
          2'd2: wr_tsr[c]  = 1'b1;
          2'd3: wr_tier[c] = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        tdr_q[c] <= '0;
        cks_q[c] <= '0;
      end
      en_q     <= '0;
      updown_q <= '0;
      load_q   <= '0;
      ovf_q    <= '0;
      udf_q    <= '0;
      ovf_ie_q <= '0;
      udf_ie_q <= '0;
      irq_q    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_tdr[c]) tdr_q[c] <= pwdata;
        if (wr_tcr[c]) cks_q[c] <= pwdata[1:0];
      end
      en_q     <= (en_q & ~wr_tcr) | (wr_tcr & {NUM_CH{pwdata[4]}});
      updown_q <= (updown_q & ~wr_tcr) | (wr_tcr & {NUM_CH{pwdata[5]}});
      // TCR bit 7 is not stored; it only launches a single-cycle load pulse.
      load_q   <= wr_tcr & {NUM_CH{pwdata[7]}};
      ovf_ie_q <= (ovf_ie_q & ~wr_tier) | (wr_tier & {NUM_CH{pwdata[0]}});
      udf_ie_q <= (udf_ie_q & ~wr_tier) | (wr_tier & {NUM_CH{pwdata[1]}});
      // Trigger is OR'd after the W1C mask so a simultaneous event wins.
      ovf_q    <= (ovf_q & ~(wr_tsr & {NUM_CH{pwdata[0]}})) | ovf_trig;
      udf_q    <= (udf_q & ~(wr_tsr & {NUM_CH{pwdata[1]}})) | udf_trig;
      irq_q    <= (ovf_q & ovf_ie_q) | (udf_q & udf_ie_q);
    end
  end

  always_comb begin
    prdata = '0;
    if (pready && !pwrite && ch_valid) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_idx == c) begin
          case (offset)
            2'd0: prdata = tdr_q[c];
            2'd1: begin
              prdata[5]   = updown_q[c];
              prdata[4]   = en_q[c];
              prdata[1:0] = cks_q[c];
            end
            2'd2: begin
              prdata[1] = udf_q[c];
              prdata[0] = ovf_q[c];
            end
            2'd3: begin
              prdata[1] = udf_ie_q[c];
              prdata[0] = ovf_ie_q[c];
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    tdr = '0;
    cks = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      tdr[c*DATA_W +: DATA_W] = tdr_q[c];
      cks[2*c +: 2]           = cks_q[c];
    end
  end

  assign en      = en_q;
  assign updown  = updown_q;
  assign load    = load_q;
  assign irq     = irq_q;
  assign irq_any = |irq_q;

endmodule

// File: tb/tb_apb_timer_regs_mc.sv
// Testbench for apb_timer_regs_mc. Two instances share the APB bus with
// separate psel lines: u_dut0 (WAIT_CYCLES=2, full register map and triggers)
// and u_dut1 (WAIT_CYCLES=0, zero-wait TDR traffic). Expected APB responses
// are queued at issue time and popped by a monitor on pready; counter-facing
// outputs are compared every cycle against a register-array reference model.
module tb_apb_timer_regs_mc;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int W0  = 2;
  localparam int W1  = 0;

  typedef struct packed {
    logic       rd;
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic [1:0]    psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [NCH-1:0] ovf_trig, udf_trig;
  logic [1:0]    exp_done;

  logic [DW-1:0]     prdata0, prdata1;
  logic              pready0, pready1, pslverr0, pslverr1;
  logic [DW*NCH-1:0] tdr0, tdr1;
  logic [NCH-1:0]    en0, ud0, load0, irq0, en1, ud1, load1, irq1;
  logic [2*NCH-1:0]  cks0, cks1;
  logic              irq_any0, irq_any1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          acc [2];
  exp_t        q0[$];
  exp_t        q1[$];

  // Reference model state
  logic [7:0]     m_tdr [2][NCH];
  logic [1:0]     m_cks [NCH];
  logic [1:0]     m_tsr [NCH];
  logic [1:0]     m_tier [NCH];
  logic [NCH-1:0] m_en, m_ud, m_load, m_irq;

  always #5 pclk = ~pclk;

  apb_timer_regs_mc #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .ovf_trig(ovf_trig), .udf_trig(udf_trig), .tdr(tdr0), .en(en0), .updown(ud0),
    .load(load0), .cks(cks0), .irq(irq0), .irq_any(irq_any0)
  );

  apb_timer_regs_mc #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
    .ovf_trig('0), .udf_trig('0), .tdr(tdr1), .en(en1), .updown(ud1),
    .load(load1), .cks(cks1), .irq(irq1), .irq_any(irq_any1)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // True when bench-side transfer d completes this cycle as a write to (c, off).
  function automatic bit hit(input int d, input int c, input int off);
    return exp_done[d] && pwrite && ((int'(paddr) >> 2) == c) && ((int'(paddr) & 3) == off);
  endfunction

  function automatic logic [7:0] rd_val(input int d, input logic [7:0] a);
    int ch  = int'(a) >> 2;
    int off = int'(a) & 3;
    if (ch >= NCH) return 8'h00;
    if (d == 1) return (off == 0) ? m_tdr[1][ch] : 8'h00;
    case (off)
      0:       return m_tdr[0][ch];
      1:       return {2'b00, m_ud[ch], m_en[ch], 2'b00, m_cks[ch]};
      2:       return {6'b0, m_tsr[ch]};
      default: return {6'b0, m_tier[ch]};
    endcase
  endfunction

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_tdr[0][c] <= '0;
        m_tdr[1][c] <= '0;
        m_cks[c]    <= '0;
        m_tsr[c]    <= '0;
        m_tier[c]   <= '0;
      end
      m_en   <= '0;
      m_ud   <= '0;
      m_load <= '0;
      m_irq  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_irq[c]  <= |(m_tsr[c] & m_tier[c]);
        m_load[c] <= hit(0, c, 1) && pwdata[7];
        if (hit(0, c, 0)) m_tdr[0][c] <= pwdata;
        if (hit(1, c, 0)) m_tdr[1][c] <= pwdata;
        if (hit(0, c, 1)) begin
          m_en[c]  <= pwdata[4];
          m_ud[c]  <= pwdata[5];
          m_cks[c] <= pwdata[1:0];
        end
        if (hit(0, c, 3)) m_tier[c] <= pwdata[1:0];
        m_tsr[c] <= (m_tsr[c] & ~(hit(0, c, 2) ? pwdata[1:0] : 2'b00)) | {udf_trig[c], ovf_trig[c]};
      end
    end
  end

  function automatic void mon(input int d, input logic pr, input logic er, input logic [7:0] rd);
    exp_t e;
    int   w = (d == 0) ? W0 : W1;
    if (psel[d] && penable) acc[d]++;
    else acc[d] = 0;
    chk($sformatf("pready_d%0d", d), 32'(pr), 32'(psel[d] && penable && exp_done[d]));
    if (pr) begin
      chk($sformatf("latency_d%0d", d), acc[d], w + 1);
      acc[d] = 0;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_pready_d%0d", d), 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("pslverr_d%0d", d), 32'(er), 32'(e.err));
        if (e.rd) chk($sformatf("prdata_d%0d", d), 32'(rd), 32'(e.data));
      end
    end else begin
      chk($sformatf("prdata_idle_d%0d", d), 32'(rd), 32'd0);
    end
  endfunction

  always @(negedge pclk) begin
    if (preset_n) begin
      mon(0, pready0, pslverr0, prdata0);
      mon(1, pready1, pslverr1, prdata1);
    end
  end

  always @(negedge pclk) begin : out_chk
    logic [31:0] et0, et1;
    logic [7:0]  ec;
    for (int c = 0; c < NCH; c++) begin
      et0[c*8 +: 8] = m_tdr[0][c];
      et1[c*8 +: 8] = m_tdr[1][c];
      ec[2*c +: 2]  = m_cks[c];
    end
    chk("tdr_d0", tdr0, et0);
    chk("tdr_d1", tdr1, et1);
    chk("en", 32'(en0), 32'(m_en));
    chk("updown", 32'(ud0), 32'(m_ud));
    chk("cks", 32'(cks0), 32'(ec));
    chk("load", 32'(load0), 32'(m_load));
    chk("irq", 32'(irq0), 32'(m_irq));
    chk("irq_any", 32'(irq_any0), 32'(|m_irq));
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic apb(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [NCH-1:0] udf_at_done = '0);
    exp_t e;
    int   w = (d == 0) ? W0 : W1;
    psel    = 2'b00;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    e.rd    = !wr;
    e.err   = (int'(a) >> 2) >= NCH;
    e.data  = wr ? 8'h00 : rd_val(d, a);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge pclk); #1 penable = 1'b1;
    repeat (w) begin
      @(posedge pclk); #1;
    end
    exp_done[d] = 1'b1;
    udf_trig    = udf_at_done;
    @(posedge pclk); #1;
    exp_done[d] = 1'b0;
    udf_trig    = '0;
    penable     = 1'b0;
  endtask

  task automatic idle(input int n);
    psel    = 2'b00;
    penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic pulse(input logic [NCH-1:0] o, input logic [NCH-1:0] u);
    psel     = 2'b00;
    penable  = 1'b0;
    ovf_trig = o;
    udf_trig = u;
    @(posedge pclk); #1;
    ovf_trig = '0;
    udf_trig = '0;
  endtask

  task automatic abort_wr(input logic [7:0] a, input logic [7:0] wd);
    psel    = 2'b01;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = wd;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    psel    = 2'b00;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    ovf_trig = '0; udf_trig = '0; exp_done = '0; acc[0] = 0; acc[1] = 0;
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(posedge pclk); #1;

    // Every valid address reads zero after reset
    for (int i = 0; i < 4 * NCH; i++) apb(0, 1'b0, 8'(i), 8'h00);
    idle(1);

    // Channel 2 TDR and TCR (load pulse, bit 7 reads back 0)
    apb(0, 1'b1, 8'h08, 8'hA5);
    apb(0, 1'b1, 8'h09, 8'hB3);
    apb(0, 1'b0, 8'h09, 8'h00);
    idle(2);
    chk("ch2_tdr_const", 32'(tdr0[23:16]), 32'hA5);
    chk("ch2_ctrl_const", {29'd0, en0[2], ud0[2], cks0[5]}, 32'h7);

    // Overflow interrupt on channel 1, then W1C
    apb(0, 1'b1, 8'h07, 8'h01);
    idle(1);
    pulse(4'b0010, 4'b0000);
    idle(2);
    chk("irq1_const", {30'd0, irq0[1], irq_any0}, 32'h3);
    apb(0, 1'b0, 8'h06, 8'h00);
    apb(0, 1'b1, 8'h06, 8'h01);
    idle(3);

    // Set beats clear on the same edge; writing 0 leaves status alone
    pulse(4'b0000, 4'b0001);
    idle(1);
    apb(0, 1'b1, 8'h02, 8'h02, 4'b0001);
    apb(0, 1'b0, 8'h02, 8'h00);
    apb(0, 1'b1, 8'h02, 8'h00);
    apb(0, 1'b0, 8'h02, 8'h00);
    idle(1);

    // Invalid channel
    apb(0, 1'b1, 8'h10, 8'hFF);
    apb(0, 1'b0, 8'h10, 8'h00);
    idle(1);

    // Zero-wait instance: back-to-back write then read
    apb(1, 1'b1, 8'h0C, 8'h5A);
    apb(1, 1'b0, 8'h0C, 8'h00);
    idle(1);

    // Aborted write must not commit
    apb(0, 1'b1, 8'h0C, 8'h3C);
    abort_wr(8'h0C, 8'h77);
    apb(0, 1'b0, 8'h0C, 8'h00);
    idle(1);

    // Randomised traffic
    repeat (250) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: begin
          a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
          apb(0, 1'($urandom), a, 8'($urandom));
        end
        4: apb(1, 1'($urandom), 8'($urandom_range(0, 4) * 4), 8'($urandom));
        default: pulse(4'($urandom), 4'($urandom));
      endcase
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Asynchronous reset in the middle of a transfer
    apb(0, 1'b1, 8'h00, 8'h99);
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h66;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #2 preset_n = 1'b0;
    #1;
    chk("pready_in_reset", 32'(pready0), 32'd0);
    chk("tdr_in_reset", tdr0, 32'd0);
    psel = 2'b00; penable = 1'b0;
    @(posedge pclk); #3 preset_n = 1'b1;
    @(posedge pclk); #1;
    apb(0, 1'b0, 8'h00, 8'h00);
    apb(0, 1'b0, 8'h04, 8'h00);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_timer_regs_mc.md
Name: apb_timer_regs_mc

Overview:
Parametrised APB slave register file for a multi-channel timer. It holds per-channel data (TDR), control (TCR), status (TSR) and interrupt-enable (TIER) registers, and drives control vectors into NUM_CH timer counters. It collects overflow/underflow events from the counters and raises per-channel and combined interrupts. Adds programmable wait states, write-1-to-clear status, a self-clearing load pulse and address-error signalling.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
DATA_W, 8, register and TDR width (>= 8)
ADDR_W, 8, paddr width
WAIT_CYCLES, 2, extra access-phase cycles before pready (0..7)

Ports:
pclk  in  1  APB clock; all logic on rising edge
preset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  byte-free word address
pwdata  in  DATA_W  write data
prdata  out  DATA_W  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid with pready
ovf_trig  in  NUM_CH  per-channel overflow pulse from counter
udf_trig  in  NUM_CH  per-channel underflow pulse from counter
tdr  out  DATA_W*NUM_CH  reload value, channel c at [c*DATA_W +: DATA_W]
en  out  NUM_CH  count enable
updown  out  NUM_CH  1 = count down
load  out  NUM_CH  one-cycle load pulse
cks  out  2*NUM_CH  clock select, channel c at [2c+1:2c]
irq  out  NUM_CH  per-channel interrupt
irq_any  out  1  OR of irq

Behaviour:
- Address map: channel c = paddr[ADDR_W-1:2], offset = paddr[1:0]. Offset 0 TDR, 1 TCR, 2 TSR, 3 TIER. Addresses with c >= NUM_CH are invalid.
- Reset values: all registers 0; prdata, pready, pslverr, load, irq, irq_any all 0.
- Wait-state counter (3 bits) increments each cycle with psel&penable&!pready.
  - pready = psel & penable & (cnt == WAIT_CYCLES).
  - Counter clears on completion or when psel is low.
  - A transfer therefore takes 1 setup + WAIT_CYCLES+1 access cycles. WAIT_CYCLES=0 gives zero-wait APB.
  - Dropping psel mid-wait aborts the transfer: no register write occurs and the counter clears.
- Commit rule: writes take effect at the clock edge where psel&penable&pwrite&pready and the address is valid.
- pslverr = pready & address invalid. Invalid writes change nothing. Invalid reads return 0.
- prdata is combinational.
  - Equals the selected register when psel&penable&!pwrite&pready; 0 otherwise.
  - Unused bits read 0.
- TDR: full DATA_W read/write.
- TCR: bits [7] load, [5] updown, [4] en, [1:0] cks are writable; other bits are read-only 0.
  - Bit 7 is not stored. Writing 1 produces load[c]=1 for exactly the next cycle; it always reads 0.
- TSR: bit0 OVF, bit1 UDF.
  - Set by ovf_trig[c] / udf_trig[c].
  - Cleared by a write with 1 in that bit position (W1C). Writing 0 has no effect.
  - A set event in the same cycle as a clear wins: the bit stays 1.
- TIER: bit0 OVF enable, bit1 UDF enable.
- irq[c] registered: irq[c] <= (TSR[0]&TIER[0]) | (TSR[1]&TIER[1]), giving one cycle of latency after a status/enable change. irq_any = |irq.
- Trigger pulses are honoured every cycle regardless of APB activity.
- Asynchronous reset mid-transfer: all state returns to reset values immediately; pready=0.
- Back-to-back transfers (setup directly after completion) are supported with no idle cycle.

Test Plan:
- Reset, then read every valid address of every channel (NUM_CH=4, WAIT_CYCLES=2) -> prdata=0, pslverr=0, pready high on the 3rd access cycle of each transfer.
- Write TDR ch2=0xA5, then TCR ch2=0xB3 -> tdr[23:16]=0xA5, en[2]=1, updown[2]=1, cks[5:4]=2'b11, load[2] high for one cycle; TCR ch2 reads 0x33.
- Pulse ovf_trig[1] with TIER ch1=0x01 -> TSR ch1 reads 0x01, irq[1] and irq_any rise one cycle after TSR sets. Write TSR ch1=0x01 -> TSR=0, irq[1] falls next cycle.
- Write 0x02 to TSR ch0 on the same edge udf_trig[0] pulses, with TSR ch0=0x02 beforehand -> UDF remains 1. Writing 0x00 to TSR leaves it unchanged.
- Access paddr=0x10 (channel 4, NUM_CH=4), write 0xFF then read -> pslverr=1 with pready, no register changes, read returns 0.
- WAIT_CYCLES=0 build: back-to-back write then read of TDR ch3 -> pready in the first access cycle, read returns the written value. Deassert psel mid-wait (WAIT_CYCLES=2) -> no write committed.
